// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the MIPS fetch stage.
// Provides a one-cycle BOOT state after reset so the first fetch address is
// RESET_VEC, then sequential / branch / jump updates with stall and a sticky
// halt. PC_NEXT_SEQ is PC+INC for the decode/link path.
// Optional return-address stack: define PC_RAS_EN to enable CALL/RET support
// with a RAS_DEPTH-entry circular LIFO; otherwise CALL/RET are ignored and
// RAS_ERR is tied low.
//
// Control handshake: there is no valid/ready pair on the control side. All
// control inputs are sampled on the rising edge of CLK while the unit is in
// RUN; the resulting PC is visible after that edge. PC_VALID qualifies PC as
// a fetch address (high only in RUN). There is no combinational path from any
// control input to PC.
module pc_unit #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned INC       = 4,
    parameter logic [31:0] RESET_VEC = 32'd0,
    parameter int          RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              STALL,
    input  logic              HALT,
    input  logic              BRANCH_TAKEN,
    input  logic [ADDR_W-1:0] BRANCH_TARGET,
    input  logic              JUMP,
    input  logic [ADDR_W-1:0] JUMP_TARGET,
    input  logic              CALL,
    input  logic              RET,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_NEXT_SEQ,
    output logic              PC_VALID,
    output logic              MISALIGN,
    output logic              RAS_ERR,
    output logic [1:0]        dbg_state
);

    // Controller states; encoding is exported on dbg_state.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Increment and the mask of address bits that must be zero in a target.
    localparam logic [ADDR_W-1:0] INC_V    = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INC - 1);
    localparam logic [ADDR_W-1:0] BOOT_PC  = ADDR_W'(RESET_VEC);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] seq_pc;

    // Targets are loaded with their low bits cleared; a nonzero low part
    // is reported through the sticky MISALIGN flag.
    logic [ADDR_W-1:0] jump_pc;
    logic [ADDR_W-1:0] branch_pc;
    logic              jump_mis;
    logic              branch_mis;

    assign seq_pc     = pc_q + INC_V;
    assign jump_pc    = JUMP_TARGET & ~LOW_MASK;
    assign branch_pc  = BRANCH_TARGET & ~LOW_MASK;
    assign jump_mis   = |(JUMP_TARGET & LOW_MASK);
    assign branch_mis = |(BRANCH_TARGET & LOW_MASK);

`ifdef PC_RAS_EN
    // Return-address stack. sp_q points at the next free slot and wraps, so
    // a push when full overwrites the oldest entry. cnt_q counts outstanding
    // calls (saturating at 2*RAS_DEPTH-1): after an overflow, returns keep
    // unwinding the circular buffer, so the extra return reads the entry
    // that wrapped. A return with cnt_q==0 is an underflow.
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ras_err_q, ras_err_d;
    logic              push_en;

    assign top_idx = sp_q - 1'b1;
`else
    // Without the stack, CALL, RET and RAS_DEPTH have no effect.
    logic unused_ras;
    assign unused_ras = &{1'b0, CALL, RET, 1'(RAS_DEPTH & 1)};
`endif

    // Next-state, next-PC and flag computation in priority order.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
`ifdef PC_RAS_EN
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        ras_err_d  = ras_err_q;
        push_en    = 1'b0;
`endif
        case (state_q)
            ST_BOOT: begin
                // PC stays at the reset vector; controls are ignored.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (HALT) begin
                    state_d = ST_HALTED;
                end else if (STALL) begin
                    pc_d = pc_q;
`ifdef PC_RAS_EN
                end else if (RET) begin
                    if (cnt_q == '0) begin
                        pc_d      = seq_pc;
                        ras_err_d = 1'b1;
                    end else begin
                        pc_d  = ras_q[top_idx];
                        sp_d  = top_idx;
                        cnt_d = cnt_q - 1'b1;
                    end
`endif
                end else if (JUMP) begin
                    pc_d = jump_pc;
                    if (jump_mis) begin
                        misalign_d = 1'b1;
                    end
`ifdef PC_RAS_EN
                    if (CALL) begin
                        push_en = 1'b1;
                        sp_d    = sp_q + 1'b1;
                        if (cnt_q >= DEPTH_C) begin
                            ras_err_d = 1'b1;
                        end
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
`endif
                end else if (BRANCH_TAKEN) begin
                    pc_d = branch_pc;
                    if (branch_mis) begin
                        misalign_d = 1'b1;
                    end
                end else begin
                    // Sequential fetch; wraps modulo 2^ADDR_W silently.
                    pc_d = seq_pc;
                end
            end
            ST_HALTED: begin
                // Frozen until reset.
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = BOOT_PC;
            end
        endcase
    end

    // Controller state, PC and sticky misalignment flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_BOOT;
            pc_q       <= BOOT_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PC_RAS_EN
    // Stack pointer, outstanding-call count and sticky error flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sp_q      <= '0;
            cnt_q     <= '0;
            ras_err_q <= 1'b0;
        end else begin
            sp_q      <= sp_d;
            cnt_q     <= cnt_d;
            ras_err_q <= ras_err_d;
        end
    end

    // Stack storage; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            ras_q[sp_q] <= seq_pc;
        end
    end

    assign RAS_ERR = ras_err_q;
`else
    assign RAS_ERR = 1'b0;
`endif

    assign PC          = pc_q;
    assign PC_NEXT_SEQ = seq_pc;
    assign PC_VALID    = (state_q == ST_RUN);
    assign MISALIGN    = misalign_q;
    assign dbg_state   = state_q;

endmodule
